// File: rtl/banco_registros_sb.sv
// banco_registros_sb: dual-issue register file with scoreboard busy bits.
// Define BANCO_BYPASS_EN to forward same-cycle writeback data to the read ports.
module banco_registros_sb #(
    parameter int DATA_W = 32,
    parameter int NREG = 32,
    parameter logic [DATA_W-1:0] PTR_INIT = 32'h10000000,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_1,
    input  logic [ADDR_W-1:0] rt_1,
    input  logic [ADDR_W-1:0] rs_2,
    input  logic [ADDR_W-1:0] rt_2,
    output logic [DATA_W-1:0] dato_A1,
    output logic [DATA_W-1:0] dato_B1,
    output logic [DATA_W-1:0] dato_A2,
    output logic [DATA_W-1:0] dato_B2,
    output logic              busy_A1,
    output logic              busy_B1,
    output logic              busy_A2,
    output logic              busy_B2,
    input  logic              iss_en_1,
    input  logic              iss_en_2,
    input  logic [ADDR_W-1:0] iss_rd_1,
    input  logic [ADDR_W-1:0] iss_rd_2,
    input  logic              wr_en_1,
    input  logic              wr_en_2,
    input  logic [ADDR_W-1:0] wr_reg_1,
    input  logic [ADDR_W-1:0] wr_reg_2,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic [DATA_W-1:0] wr_data_2,
    output logic [ADDR_W:0]   n_busy
);
    localparam logic [ADDR_W:0] n_sat = (ADDR_W+1)'(NREG - 1);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy, busy_n;
    logic [ADDR_W:0]   cnt;

    function automatic logic issued(input logic [ADDR_W-1:0] a);
        return (iss_en_1 && iss_rd_1 == a) || (iss_en_2 && iss_rd_2 == a);
    endfunction

    function automatic logic [DATA_W-1:0] leer(input logic [ADDR_W-1:0] a);
`ifdef BANCO_BYPASS_EN
        return (a != '0 && wr_en_1 && wr_reg_1 == a) ? wr_data_1 :
               (a != '0 && wr_en_2 && wr_reg_2 == a) ? wr_data_2 : regs[a];
`else
        return regs[a];
`endif
    endfunction

    function automatic logic ocupado(input logic [ADDR_W-1:0] a);
`ifdef BANCO_BYPASS_EN
        // A register being written back this cycle only stays busy if re-issued now
        return (a != '0 && ((wr_en_1 && wr_reg_1 == a) || (wr_en_2 && wr_reg_2 == a))) ?
               issued(a) : busy[a];
`else
        return busy[a];
`endif
    endfunction

    always_comb begin
        dato_A1 = leer(rs_1);
        dato_B1 = leer(rt_1);
        dato_A2 = leer(rs_2);
        dato_B2 = leer(rt_2);
        busy_A1 = ocupado(rs_1);
        busy_B1 = ocupado(rt_1);
        busy_A2 = ocupado(rs_2);
        busy_B2 = ocupado(rt_2);
    end

    // Clears first, then sets: the issuing instruction is younger than the writeback
    always_comb begin
        busy_n = busy;
        if (wr_en_1) busy_n[wr_reg_1] = 1'b0;
        if (wr_en_2) busy_n[wr_reg_2] = 1'b0;
        if (iss_en_1) busy_n[iss_rd_1] = 1'b1;
        if (iss_en_2) busy_n[iss_rd_2] = 1'b1;
        busy_n[0] = 1'b0;
        cnt = '0;
        for (int i = 1; i < NREG; i++) cnt = cnt + (ADDR_W+1)'(busy_n[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= (i == 11 || i == 12) ? PTR_INIT : '0;
            busy <= '0;
            n_busy <= '0;
        end else begin
            if (wr_en_2 && wr_reg_2 != '0) regs[wr_reg_2] <= wr_data_2;
            if (wr_en_1 && wr_reg_1 != '0) regs[wr_reg_1] <= wr_data_1;
            busy <= busy_n;
            n_busy <= (cnt > n_sat) ? n_sat : cnt;
        end
    end
endmodule

// File: tb/tb_banco_registros_sb.sv
// tb_banco_registros_sb: directed plan plus random traffic against an array model.
module tb_banco_registros_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_1, rt_1, rs_2, rt_2;
    logic [31:0] dato_A1, dato_B1, dato_A2, dato_B2;
    logic        busy_A1, busy_B1, busy_A2, busy_B2;
    logic        iss_en_1, iss_en_2, wr_en_1, wr_en_2;
    logic [4:0]  iss_rd_1, iss_rd_2, wr_reg_1, wr_reg_2;
    logic [31:0] wr_data_1, wr_data_2;
    logic [5:0]  n_busy;

    int n_pass = 0, n_total = 0;
    bit do_chk = 0;
    logic [31:0] m_reg [32];
    bit m_busy [32];
    int m_cnt;

    banco_registros_sb dut (
        .clk(clk), .rst(rst),
        .rs_1(rs_1), .rt_1(rt_1), .rs_2(rs_2), .rt_2(rt_2),
        .dato_A1(dato_A1), .dato_B1(dato_B1), .dato_A2(dato_A2), .dato_B2(dato_B2),
        .busy_A1(busy_A1), .busy_B1(busy_B1), .busy_A2(busy_A2), .busy_B2(busy_B2),
        .iss_en_1(iss_en_1), .iss_en_2(iss_en_2), .iss_rd_1(iss_rd_1), .iss_rd_2(iss_rd_2),
        .wr_en_1(wr_en_1), .wr_en_2(wr_en_2), .wr_reg_1(wr_reg_1), .wr_reg_2(wr_reg_2),
        .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .n_busy(n_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_dato(input logic [4:0] a);
`ifdef BANCO_BYPASS_EN
        if (a != 0 && wr_en_1 && wr_reg_1 == a) return wr_data_1;
        if (a != 0 && wr_en_2 && wr_reg_2 == a) return wr_data_2;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
`ifdef BANCO_BYPASS_EN
        if (a != 0 && ((wr_en_1 && wr_reg_1 == a) || (wr_en_2 && wr_reg_2 == a)))
            return (iss_en_1 && iss_rd_1 == a) || (iss_en_2 && iss_rd_2 == a);
`endif
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        chk("dato_A1", dato_A1, exp_dato(rs_1));
        chk("dato_B1", dato_B1, exp_dato(rt_1));
        chk("dato_A2", dato_A2, exp_dato(rs_2));
        chk("dato_B2", dato_B2, exp_dato(rt_2));
        chk("busy_A1", 32'(busy_A1), 32'(exp_busy(rs_1)));
        chk("busy_B1", 32'(busy_B1), 32'(exp_busy(rt_1)));
        chk("busy_A2", 32'(busy_A2), 32'(exp_busy(rs_2)));
        chk("busy_B2", 32'(busy_B2), 32'(exp_busy(rt_2)));
        chk("n_busy", 32'(n_busy), 32'(m_cnt));
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = (i == 11 || i == 12) ? 32'h10000000 : 32'h0;
                m_busy[i] = 0;
            end
        end else begin
            if (wr_en_2 && wr_reg_2 != 0) m_reg[wr_reg_2] = wr_data_2;
            if (wr_en_1 && wr_reg_1 != 0) m_reg[wr_reg_1] = wr_data_1;
            if (wr_en_1) m_busy[wr_reg_1] = 0;
            if (wr_en_2) m_busy[wr_reg_2] = 0;
            if (iss_en_1 && iss_rd_1 != 0) m_busy[iss_rd_1] = 1;
            if (iss_en_2 && iss_rd_2 != 0) m_busy[iss_rd_2] = 1;
        end
        m_cnt = 0;
        foreach (m_busy[i]) m_cnt += int'(m_busy[i]);
        if (m_cnt > 31) m_cnt = 31;
    endtask

    // Entered just after a rising edge with inputs already driven
    task automatic tick();
        #4;
        if (do_chk) check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        iss_en_1 = 0; iss_en_2 = 0; wr_en_1 = 0; wr_en_2 = 0;
        iss_rd_1 = 0; iss_rd_2 = 0; wr_reg_1 = 0; wr_reg_2 = 0;
        wr_data_1 = 0; wr_data_2 = 0;
    endtask

    initial begin
        rst = 1; idle();
        rs_1 = 0; rt_1 = 0; rs_2 = 0; rt_2 = 0;
        @(posedge clk); #1;
        tick();
        do_chk = 1;
        rst = 0; rs_1 = 11; rt_1 = 12; rs_2 = 5; #1;
        chk("rst_r11", dato_A1, 32'h10000000);
        chk("rst_r12", dato_B1, 32'h10000000);
        chk("rst_r5", dato_A2, 32'h0);
        chk("rst_busy", {28'h0, busy_A1, busy_B1, busy_A2, busy_B2}, 32'h0);
        chk("rst_nbusy", 32'(n_busy), 32'h0);

        wr_en_2 = 1; wr_reg_2 = 8; wr_data_2 = 32'hDEADBEEF; tick();
        idle(); rt_2 = 8; #1;
        chk("wr_r8", dato_B2, 32'hDEADBEEF);
        wr_en_1 = 1; wr_reg_1 = 0; wr_data_1 = 32'h1; iss_en_1 = 1; iss_rd_1 = 0; tick();
        idle(); rs_1 = 0; #1;
        chk("wr_r0", dato_A1, 32'h0);
        chk("iss_r0", 32'(busy_A1), 32'h0);

        wr_en_1 = 1; wr_reg_1 = 9; wr_data_1 = 32'hA;
        wr_en_2 = 1; wr_reg_2 = 9; wr_data_2 = 32'hB; tick();
        idle(); rs_2 = 9; #1;
        chk("conflict_r9", dato_A2, 32'hA);

        iss_en_1 = 1; iss_rd_1 = 10; rs_1 = 10; tick();
        idle(); #1;
        chk("iss_busy", 32'(busy_A1), 32'h1);
        chk("iss_nbusy", 32'(n_busy), 32'h1);
        iss_en_2 = 1; iss_rd_2 = 10; wr_en_1 = 1; wr_reg_1 = 10; wr_data_1 = 32'h1234; tick();
        idle(); #1;
        chk("setclr_busy", 32'(busy_A1), 32'h1);
        chk("setclr_nbusy", 32'(n_busy), 32'h1);
        wr_en_1 = 1; wr_reg_1 = 10; wr_data_1 = 32'h5678; tick();
        idle(); #1;
        chk("clr_busy", 32'(busy_A1), 32'h0);
        chk("clr_nbusy", 32'(n_busy), 32'h0);
        iss_en_1 = 1; iss_rd_1 = 7; iss_en_2 = 1; iss_rd_2 = 7; tick();
        idle(); #1;
        chk("dup_iss_nbusy", 32'(n_busy), 32'h1);
        wr_en_2 = 1; wr_reg_2 = 7; tick(); idle();

        iss_en_1 = 1; iss_rd_1 = 3; iss_en_2 = 1; iss_rd_2 = 4; tick();
        idle(); iss_en_1 = 1; iss_rd_1 = 5; tick();
        idle(); #1;
        chk("pre_rst_nbusy", 32'(n_busy), 32'h3);
        rst = 1; iss_en_1 = 1; iss_rd_1 = 6; tick();
        rst = 0; idle(); rs_1 = 6; rt_1 = 3; #1;
        chk("mid_rst_r6", 32'(busy_A1), 32'h0);
        chk("mid_rst_r3", 32'(busy_B1), 32'h0);
        chk("mid_rst_nbusy", 32'(n_busy), 32'h0);

        wr_en_1 = 1; wr_reg_1 = 17; wr_data_1 = 32'h77; tick();
        idle(); iss_en_1 = 1; iss_rd_1 = 17; tick();
        idle(); wr_en_2 = 1; wr_reg_2 = 17; wr_data_2 = 32'h55; rs_1 = 17; #1;
`ifdef BANCO_BYPASS_EN
        chk("byp_data", dato_A1, 32'h55);
        chk("byp_busy", 32'(busy_A1), 32'h0);
`else
        chk("byp_data", dato_A1, 32'h77);
        chk("byp_busy", 32'(busy_A1), 32'h1);
`endif
        tick();
        idle(); #1;
        chk("byp_next", dato_A1, 32'h55);
        chk("byp_next_busy", 32'(busy_A1), 32'h0);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            rs_1 = 5'($urandom); rt_1 = 5'($urandom); rs_2 = 5'($urandom); rt_2 = 5'($urandom);
            iss_en_1 = $urandom_range(0, 2) == 0; iss_rd_1 = 5'($urandom);
            iss_en_2 = $urandom_range(0, 2) == 0; iss_rd_2 = 5'($urandom);
            wr_en_1 = $urandom_range(0, 2) == 0; wr_reg_1 = 5'($urandom);
            wr_en_2 = $urandom_range(0, 2) == 0; wr_reg_2 = 5'($urandom);
            wr_data_1 = $urandom; wr_data_2 = $urandom;
            if ($urandom_range(0, 3) == 0) rs_1 = wr_reg_1;
            if ($urandom_range(0, 3) == 0) rt_2 = wr_reg_2;
            tick();
        end
        rst = 0; idle(); #1;
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
